// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared pixel types and blender state encoding
// Purpose: pixel layout, channel widths, blender FSM states and the alpha
// expansion helper shared by the blender and its lanes.
// Ports: none (package).
package gpu_pkg;

  localparam int RGBA_W  = 8;
  localparam int PIXEL_W = 32;

  // Same word layout as texture RAM and framebuffer: r in [31:24], a in [7:0].
  typedef struct packed {
    logic [RGBA_W-1:0] r;
    logic [RGBA_W-1:0] g;
    logic [RGBA_W-1:0] b;
    logic [RGBA_W-1:0] a;
  } rgba_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    BLEND,
    WRITE,
    SKIP
  } blend_state_t;

  // Maps 0..255 onto 0..256 so that a >> 8 blend is exact at both ends.
  function automatic logic [RGBA_W:0] alpha_prime(input logic [RGBA_W-1:0] a);
    return {1'b0, a} + {{RGBA_W{1'b0}}, a[RGBA_W-1]};
  endfunction

endpackage

// File: rtl/alpha_blender_if.sv
// rtl/alpha_blender_if.sv - fragment request and framebuffer port bundles
// Purpose: groups the upstream fragment handshake and the framebuffer RAM
// port of the alpha blender.
// blend_req_if: blend_req, blend_addr, red/green/blue/alpha (to blender),
//               busy, blend_done (from blender). master = upstream.
// fb_if:        fb_read_en/addr, fb_write_en/addr/data (from blender),
//               fb_read_data (to blender). master = blender.
interface blend_req_if #(
  parameter int ADDR_WIDTH = 17
);
  import gpu_pkg::*;

  logic                  blend_req;
  logic [ADDR_WIDTH-1:0] blend_addr;
  logic [RGBA_W-1:0]     red;
  logic [RGBA_W-1:0]     green;
  logic [RGBA_W-1:0]     blue;
  logic [RGBA_W-1:0]     alpha;
  logic                  busy;
  logic                  blend_done;

  modport master (
    output blend_req, blend_addr, red, green, blue, alpha,
    input  busy, blend_done
  );

  modport slave (
    input  blend_req, blend_addr, red, green, blue, alpha,
    output busy, blend_done
  );
endinterface

interface fb_if #(
  parameter int ADDR_WIDTH = 17
);
  import gpu_pkg::*;

  logic                  fb_read_en;
  logic [ADDR_WIDTH-1:0] fb_read_addr;
  logic [PIXEL_W-1:0]    fb_read_data;
  logic                  fb_write_en;
  logic [ADDR_WIDTH-1:0] fb_write_addr;
  logic [PIXEL_W-1:0]    fb_write_data;

  modport master (
    output fb_read_en, fb_read_addr, fb_write_en, fb_write_addr, fb_write_data,
    input  fb_read_data
  );

  modport slave (
    input  fb_read_en, fb_read_addr, fb_write_en, fb_write_addr, fb_write_data,
    output fb_read_data
  );
endinterface

// File: rtl/blend_lane.sv
// rtl/blend_lane.sv - combinational single-channel source-over blend
// Purpose: out = (src*a' + dst*(256-a')) >> 8 for one colour channel.
// Ports: src, dst (8-bit channel values), alpha_p (expanded alpha 0..256),
//        out (8-bit blended channel).
module blend_lane
  import gpu_pkg::*;
(
  input  logic [RGBA_W-1:0] src,
  input  logic [RGBA_W-1:0] dst,
  input  logic [RGBA_W:0]   alpha_p,
  output logic [RGBA_W-1:0] out
);

  logic [RGBA_W:0] inv_p;
  logic [15:0]     src_term;
  logic [15:0]     dst_term;
  logic [15:0]     acc;

  assign inv_p    = 9'd256 - alpha_p;
  assign src_term = {8'b0, src} * {7'b0, alpha_p};
  assign dst_term = {8'b0, dst} * {7'b0, inv_p};
  // The weights sum to 256, so the total never exceeds 255*256 and fits 16 bits.
  assign acc      = src_term + dst_term;
  assign out      = 8'(acc >> 8);

endmodule

// File: rtl/alpha_blender.sv
// rtl/alpha_blender.sv - read-modify-write source-over framebuffer blender
// Purpose: accepts one texel per fragment, reads the destination pixel,
// blends source-over and writes it back. Transparent texels retire with no
// RAM access; opaque texels are written without a read. One fragment in flight.
// Ports: clk, reset (sync, active-high),
//        req (blend_req_if.slave): fragment request, busy, blend_done,
//        fb  (fb_if.master): framebuffer read/write port.
module alpha_blender
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 17,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  blend_req_if.slave  req,
  fb_if.master        fb
);

  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  blend_state_t          state;
  blend_state_t          state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  rgba_t                 src_q;
  rgba_t                 dst_q;
  rgba_t                 result_q;
  logic [1:0]            wait_cnt;

  rgba_t                 src_in;
  rgba_t                 blend_px;
  logic                  wait_last;
  logic [RGBA_W:0]       alpha_p;
  logic [RGBA_W:0]       inv_p;
  logic [15:0]           dst_a_scaled;
  logic [RGBA_W:0]       a_sum;
  logic [RGBA_W-1:0]     blend_r;
  logic [RGBA_W-1:0]     blend_g;
  logic [RGBA_W-1:0]     blend_b;
  logic [RGBA_W-1:0]     blend_a;

  assign src_in    = {req.red, req.green, req.blue, req.alpha};
  assign wait_last = (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req.blend_req) begin
          if (src_in.a == 8'h00) begin
            state_next = SKIP;
          end else if (src_in.a == 8'hFF) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:    state_next = WAIT;
      WAIT:    if (wait_last) state_next = BLEND;
      BLEND:   state_next = WRITE;
      WRITE:   state_next = IDLE;
      SKIP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req.busy       = (state != IDLE);
    req.blend_done = (state == WRITE) || (state == SKIP);
    fb.fb_read_en  = (state == READ);
    fb.fb_write_en = (state == WRITE);
  end

  assign fb.fb_read_addr  = addr_q;
  assign fb.fb_write_addr = addr_q;
  assign fb.fb_write_data = result_q;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      result_q <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req.blend_req) begin
            addr_q   <= req.blend_addr;
            src_q    <= src_in;
            wait_cnt <= '0;
            // Opaque texels bypass the read and BLEND, so the result is formed here.
            if (src_in.a == 8'hFF) begin
              result_q <= {src_in.r, src_in.g, src_in.b, 8'hFF};
            end
          end
        end
        WAIT: begin
          if (wait_last) begin
            dst_q <= fb.fb_read_data;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        BLEND: result_q <= blend_px;
        default: ;
      endcase
    end
  end

  assign alpha_p = alpha_prime(src_q.a);
  assign inv_p   = 9'd256 - alpha_p;

  blend_lane u_lane_r (.src(src_q.r), .dst(dst_q.r), .alpha_p(alpha_p), .out(blend_r));
  blend_lane u_lane_g (.src(src_q.g), .dst(dst_q.g), .alpha_p(alpha_p), .out(blend_g));
  blend_lane u_lane_b (.src(src_q.b), .dst(dst_q.b), .alpha_p(alpha_p), .out(blend_b));

  // Coverage accumulates: src alpha plus the destination's remaining coverage.
  assign dst_a_scaled = {8'b0, dst_q.a} * {7'b0, inv_p};
  assign a_sum        = {1'b0, src_q.a} + 9'(dst_a_scaled >> 8);
  assign blend_a      = a_sum[RGBA_W] ? 8'hFF : a_sum[RGBA_W-1:0];

  assign blend_px = {blend_r, blend_g, blend_b, blend_a};

endmodule

// File: tb/tb_alpha_blender.sv
// tb/tb_alpha_blender.sv - scoreboard bench for alpha_blender at read latency 1 and 3
module tb_alpha_blender;

  localparam int AW = 17;

  typedef struct {
    bit              wr;
    logic [AW-1:0]   addr;
    logic [31:0]     data;
    int              rd_cyc;
    int              done_cyc;
  } exp_t;

  localparam logic [AW-1:0] BB_ADDR [10] = '{
    17'h80, 17'h81, 17'h81, 17'h82, 17'h83, 17'h80, 17'h82, 17'h80, 17'h83, 17'h84
  };
  localparam logic [31:0] BB_PIX [10] = '{
    32'h20406080, 32'hFFFFFF40, 32'h00000000, 32'h102030FF, 32'h0A0B0CC0,
    32'hC0C0C040, 32'h55AA5501, 32'h102030C0, 32'h13579BFF, 32'h2468AC7F
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_req = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [31:0]   s_pix = '0;
  logic          s_has_exp = 1'b0;
  logic [31:0]   s_exp = '0;
  logic          s_finish = 1'b0;
  logic          fin_done = 1'b0;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  always #5 clk = ~clk;

  blend_req_if #(.ADDR_WIDTH(AW)) rq0 ();
  blend_req_if #(.ADDR_WIDTH(AW)) rq1 ();
  fb_if        #(.ADDR_WIDTH(AW)) fb0 ();
  fb_if        #(.ADDR_WIDTH(AW)) fb1 ();

  alpha_blender #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .req(rq0), .fb(fb0)
  );
  alpha_blender #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .req(rq1), .fb(fb1)
  );

  assign rq0.blend_req = s_req;  assign rq1.blend_req = s_req;
  assign rq0.blend_addr = s_addr; assign rq1.blend_addr = s_addr;
  assign rq0.red = s_pix[31:24];   assign rq1.red = s_pix[31:24];
  assign rq0.green = s_pix[23:16]; assign rq1.green = s_pix[23:16];
  assign rq0.blue = s_pix[15:8];   assign rq1.blue = s_pix[15:8];
  assign rq0.alpha = s_pix[7:0];   assign rq1.alpha = s_pix[7:0];

  logic          busy_w [2];
  logic          done_w [2];
  logic          rd_en_w [2];
  logic          wr_en_w [2];
  logic [AW-1:0] rd_addr_w [2];
  logic [AW-1:0] wr_addr_w [2];
  logic [31:0]   wr_data_w [2];

  assign busy_w[0] = rq0.busy;          assign busy_w[1] = rq1.busy;
  assign done_w[0] = rq0.blend_done;    assign done_w[1] = rq1.blend_done;
  assign rd_en_w[0] = fb0.fb_read_en;   assign rd_en_w[1] = fb1.fb_read_en;
  assign wr_en_w[0] = fb0.fb_write_en;  assign wr_en_w[1] = fb1.fb_write_en;
  assign rd_addr_w[0] = fb0.fb_read_addr;   assign rd_addr_w[1] = fb1.fb_read_addr;
  assign wr_addr_w[0] = fb0.fb_write_addr;  assign wr_addr_w[1] = fb1.fb_write_addr;
  assign wr_data_w[0] = fb0.fb_write_data;  assign wr_data_w[1] = fb1.fb_write_data;

  function automatic int lat(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    if (a == 17'h10) return 32'h000000FF;
    if (a == 17'h20) return 32'h00C800FF;
    return 32'h00000000;
  endfunction

  // Framebuffer models: data is valid only in the cycle READ_LATENCY after the strobe.
  logic [31:0]   mem0 [int];
  logic [31:0]   mem1 [int];
  logic          rd_pend [2] = '{1'b0, 1'b0};
  int            rd_age [2] = '{0, 0};
  logic [AW-1:0] rd_a [2];
  logic [31:0]   rd_q [2] = '{32'hDEADBEEF, 32'hDEADBEEF};

  assign fb0.fb_read_data = rd_q[0];
  assign fb1.fb_read_data = rd_q[1];

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rd_en_w[l]) begin
        rd_pend[l] = 1'b1;
        rd_age[l]  = 0;
        rd_a[l]    = rd_addr_w[l];
      end else if (rd_pend[l]) begin
        rd_age[l]++;
      end
    end
    if (wr_en_w[0]) mem0[int'(wr_addr_w[0])] = wr_data_w[0];
    if (wr_en_w[1]) mem1[int'(wr_addr_w[1])] = wr_data_w[1];
    rd_q[0] = (rd_pend[0] && rd_age[0] == 1) ?
              (mem0.exists(int'(rd_a[0])) ? mem0[int'(rd_a[0])] : init_word(rd_a[0])) : 32'hDEADBEEF;
    rd_q[1] = (rd_pend[1] && rd_age[1] == 3) ?
              (mem1.exists(int'(rd_a[1])) ? mem1[int'(rd_a[1])] : init_word(rd_a[1])) : 32'hDEADBEEF;
  end

  // Scoreboard state
  exp_t        q [2][$];
  logic [31:0] sh0 [int];
  logic [31:0] sh1 [int];
  bit          idle_chk [2] = '{1'b0, 1'b0};
  bit          prev_reset = 1'b0;

  function automatic logic [31:0] sh_read(input int l, input logic [AW-1:0] a);
    if (l == 0) return sh0.exists(int'(a)) ? sh0[int'(a)] : init_word(a);
    return sh1.exists(int'(a)) ? sh1[int'(a)] : init_word(a);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] src, input logic [31:0] dst);
    int ap, s, d, o;
    logic [31:0] r;
    ap = int'(src[7:0]);
    if (ap >= 128) ap++;
    for (int k = 1; k < 4; k++) begin
      s = int'(src[8*k +: 8]);
      d = int'(dst[8*k +: 8]);
      r[8*k +: 8] = 8'((s * ap + d * (256 - ap)) / 256);
    end
    o = int'(src[7:0]) + (int'(dst[7:0]) * (256 - ap)) / 256;
    if (o > 255) o = 255;
    r[7:0] = 8'(o);
    return r;
  endfunction

  task automatic check(input string name, input int l, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s lane%0d cycle %0d: got %0h want %0h", name, l, cyc, got, want);
    end
  endtask

  task automatic mon_lane(input int l);
    exp_t h;
    bit   have, exp_rd, exp_done;
    have = (q[l].size() > 0);
    if (have) h = q[l][0];
    exp_rd   = have && (h.rd_cyc == cyc);
    exp_done = have && (h.done_cyc == cyc);
    check("strobe_excl", l, rd_en_w[l] & wr_en_w[l], 0);
    if (idle_chk[l]) begin
      check("busy_after_done", l, busy_w[l], 0);
      idle_chk[l] = 1'b0;
    end
    if (have) check("busy_inflight", l, busy_w[l], 1);
    check("read_strobe", l, rd_en_w[l], exp_rd);
    if (exp_rd) check("read_addr", l, rd_addr_w[l], h.addr);
    check("blend_done", l, done_w[l], exp_done);
    check("write_strobe", l, wr_en_w[l], exp_done && h.wr);
    if (exp_done && h.wr) begin
      check("write_addr", l, wr_addr_w[l], h.addr);
      check("write_data", l, wr_data_w[l], h.data);
    end
    if (exp_done) begin
      void'(q[l].pop_front());
      idle_chk[l] = 1'b1;
    end
  endtask

  task automatic push_lane(input int l);
    exp_t e;
    if (s_req && !busy_w[l]) begin
      e.addr   = s_addr;
      e.data   = '0;
      e.rd_cyc = -1;
      if (s_pix[7:0] == 8'h00) begin
        e.wr       = 1'b0;
        e.done_cyc = cyc + 1;
      end else if (s_pix[7:0] == 8'hFF) begin
        e.wr       = 1'b1;
        e.done_cyc = cyc + 1;
      end else begin
        e.wr       = 1'b1;
        e.rd_cyc   = cyc + 1;
        e.done_cyc = cyc + 3 + lat(l);
      end
      if (e.wr) begin
        e.data = s_has_exp ? s_exp : model(s_pix, sh_read(l, s_addr));
        if (l == 0) sh0[int'(s_addr)] = e.data;
        else        sh1[int'(s_addr)] = e.data;
      end
      q[l].push_back(e);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (prev_reset) begin
      for (int l = 0; l < 2; l++) begin
        check("reset_ctrl", l, {rd_addr_w[l], wr_addr_w[l], busy_w[l], done_w[l], rd_en_w[l], wr_en_w[l]}, 0);
        check("reset_wdata", l, wr_data_w[l], 0);
      end
    end
    prev_reset = reset;
    if (reset) begin
      q[0].delete();
      q[1].delete();
      idle_chk[0] = 1'b0;
      idle_chk[1] = 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        mon_lane(l);
        push_lane(l);
      end
    end
    if (s_finish && !fin_done) begin
      check("drained", 0, q[0].size(), 0);
      check("drained", 1, q[1].size(), 0);
      fin_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!rq0.busy && !rq1.busy) return;
      step();
    end
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [31:0] pix, input logic [31:0] expv);
    wait_idle();
    s_addr    = a;
    s_pix     = pix;
    s_exp     = expv;
    s_has_exp = 1'b1;
    s_req     = 1'b1;
    step();
    s_req     = 1'b0;
    s_has_exp = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();

    issue(17'h00010, 32'hFF000080, 32'h800000FE);  // mid alpha
    issue(17'h00020, 32'h00000040, 32'h009600FF);  // quarter alpha
    issue(17'h00030, 32'hAABBCC00, 32'h00000000);  // transparent
    issue(17'h1FFFF, 32'h123456FF, 32'h123456FF);  // opaque, top address
    issue(17'h00040, 32'hFF0000FE, 32'hFE0000FE);  // alpha just below opaque
    issue(17'h00050, 32'h80402001, 32'h00000001);  // alpha just above transparent
    wait_idle();

    // Request held high with a new fragment every cycle.
    for (int i = 0; i < 10; i++) begin
      s_req  = 1'b1;
      s_addr = BB_ADDR[i];
      s_pix  = BB_PIX[i];
      step();
    end
    s_req = 1'b0;
    wait_idle();

    // Reset while both blenders wait on the read.
    s_addr = 17'h00070;
    s_pix  = 32'h11223380;
    s_req  = 1'b1;
    step();
    s_req  = 1'b0;
    step();
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    issue(17'h00060, 32'hC8000040, 32'h32000040);
    wait_idle();
    step();
    step();

    s_finish = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
